// File: rtl/inst_f_pf.sv
// Instruction fetch with a small prefetch FIFO. Requests run ahead of ID up to DEPTH
// in flight. After a redirect, responses still in flight from the old path are dropped.
module inst_f_pf #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            hazard,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] fpc, rpc;
  logic [CW-1:0]   count, outstanding, drop_cnt, out_nxt;
  logic [PW-1:0]   wptr, rptr;
  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [CW:0]     inflight;
  logic            gnt, rsp, enq, deq, not_empty;
  logic [XLEN-1:0] tgt;
  logic            unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign tgt        = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    inflight  = {1'b0, count} + {1'b0, outstanding};
    not_empty = (count != '0);
    imem_req  = !rst && !redirect && (drop_cnt == '0) && (inflight < (CW+1)'(DEPTH));
    gnt       = imem_req && imem_gnt;
    // A response with nothing outstanding belongs to a pre-reset request.
    rsp       = imem_rvalid && (outstanding != '0);
    enq       = rsp && (drop_cnt == '0) && !redirect;
    deq       = not_empty && !hazard;
    out_nxt   = outstanding + CW'(gnt) - CW'(rsp);
  end

  assign imem_addr = fpc;
  assign id_valid  = !rst && not_empty;
  assign id_instr  = id_valid ? mem_instr[rptr] : '0;
  assign id_pc     = rst ? RESET_PC : (not_empty ? mem_pc[rptr] : rpc);
  assign id_pc4    = id_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect) begin
        // Flush the buffer; everything still in flight after this cycle is stale.
        fpc      <= tgt;
        rpc      <= tgt;
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
        drop_cnt <= out_nxt;
        state    <= (out_nxt != '0) ? DRAIN : RUN;
      end else begin
        if (gnt) fpc <= fpc + XLEN'(4);
        if (rsp && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= RUN;
        end
        if (enq) begin
          mem_instr[wptr] <= imem_rdata;
          mem_pc[wptr]    <= rpc;
          wptr            <= wptr + PW'(1);
          rpc             <= rpc + XLEN'(4);
        end
        if (deq) rptr <= rptr + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
endmodule

// File: doc/inst_f_pf.md
INST_F_PF -- requirements
Module: inst_f_pf

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC and address width (>=16).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the prefetch buffer entry count (power of two, >=2).
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address after reset.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port redirect, input, 1 bit: taken branch or jump from EX.
REQ-007 The block SHALL have port redirect_pc, input, XLEN bits: new fetch target.
REQ-008 The block SHALL have port hazard, input, 1 bit: ID stall; holds the buffer head.
REQ-009 The block SHALL have ports imem_req, output, 1 bit, and imem_addr, output, XLEN bits: fetch request.
REQ-010 The block SHALL have port imem_gnt, input, 1 bit: request accepted when imem_req and imem_gnt are both 1.
REQ-011 The block SHALL have ports imem_rvalid, input, 1 bit, and imem_rdata, input, 32 bits: in-order response, arriving at least 1 cycle after its grant.
REQ-012 The block SHALL have ports id_valid, output, 1 bit, and id_instr, output, 32 bits: instruction to ID.
REQ-013 The block SHALL have ports id_pc, output, XLEN bits, and id_pc4, output, XLEN bits: PC of id_instr, and that PC + 4.

Function
REQ-014 The block SHALL hold a fetch PC (fpc); imem_addr SHALL equal fpc.
REQ-015 imem_req SHALL be 1 iff (count + outstanding) < DEPTH and drop_cnt == 0; imem_req SHALL also be 0 in the redirect cycle.
REQ-016 On a grant, fpc SHALL advance by 4 and outstanding SHALL increment.
REQ-017 On imem_rvalid, outstanding SHALL decrement; if drop_cnt > 0, the response SHALL be discarded and drop_cnt decremented; otherwise {rpc, imem_rdata} SHALL be written at the FIFO tail and rpc SHALL advance by 4.
REQ-018 id_valid SHALL be 1 iff the FIFO is not empty; id_instr and id_pc SHALL show the head entry; id_pc4 SHALL be id_pc + 4, computed modulo 2^XLEN.
REQ-019 The head SHALL be dequeued when id_valid == 1 and hazard == 0; with hazard == 1, the head and all outputs SHALL hold.
REQ-020 A simultaneous enqueue and dequeue SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 Overflow SHALL be impossible by construction (REQ-015); latency SHALL be: response cycle + 1 -> id_valid when the FIFO was empty.
REQ-022 On redirect, the FIFO SHALL be flushed (count = 0), fpc and rpc SHALL be set to {redirect_pc[XLEN-1:2], 2'b00}, and the head SHALL be dropped regardless of hazard.
REQ-023 On redirect, drop_cnt SHALL be set to the outstanding count after that cycle's grant and rvalid; any response arriving in the redirect cycle SHALL itself be discarded.
REQ-024 The state machine SHALL have states RUN (normal operation) and DRAIN (drop_cnt > 0); redirect with nonzero outstanding SHALL go to DRAIN; DRAIN SHALL return to RUN when drop_cnt reaches 0.
REQ-025 A redirect received while in DRAIN SHALL update fpc and rpc and recompute drop_cnt per REQ-023.
REQ-026 fpc and rpc SHALL wrap modulo 2^XLEN without error.

Reset
REQ-027 While rst == 1: fpc = rpc = RESET_PC; count = outstanding = drop_cnt = 0; state = RUN; imem_req = 0; id_valid = 0; id_instr = 0; id_pc = RESET_PC; id_pc4 = RESET_PC + 4.
REQ-028 Reset SHALL take priority over redirect, hazard and grant; responses arriving during reset, or belonging to pre-reset requests, SHALL be ignored.
REQ-029 The first imem_req SHALL assert in the first cycle after rst deasserts.

Verification
REQ-030 Reset then imem_gnt always 1 with rvalid 1 cycle later and hazard 0 -> imem_addr 0,4,8,...; id_pc 0,4,8 on consecutive cycles; id_pc4 = id_pc + 4.
REQ-031 hazard = 1 held for 10 cycles, DEPTH = 4 -> exactly 4 entries buffered, imem_req drops to 0, id_instr stable; on release, 4 back-to-back dequeues.
REQ-032 Redirect to 32'h100 with 2 requests outstanding -> both responses discarded, id_valid = 0 until the instruction at 32'h100, id_pc = 32'h100.
REQ-033 Redirect to 32'h203 -> fetch at 32'h200.
REQ-034 Redirect and rvalid in the same cycle, then a second redirect during DRAIN -> no stale instruction ever presented; final stream starts at the second target.
REQ-035 rst asserted mid-stream with the FIFO full -> next cycle id_valid = 0, imem_addr = RESET_PC.
